// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: the memory end of the data_sram interface.
// Accepts en/byte-wen/addr/wdata from EX and returns registered read data one
// clock after acceptance, or after WAIT_CYCLES wait states (stallreq held
// high while the access is in wait states).
// Optional feature macro: DSRAM_ERR_EN. When defined, accesses with nonzero
// addr[31:ADDR_W+2] become address errors: writes are dropped, reads return
// 32'hDEADBEEF, and err pulses for one cycle. When undefined, the upper
// address bits alias and err is tied 0.
module data_sram_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        err
);

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WC    = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [31:0]       mem [DEPTH];

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic [3:0]        wen_q;
    logic [31:0]       wdata_q;
    logic              bad_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [ADDR_W-1:0] in_idx;
    logic              in_bad;

    // Access performed at the coming edge: either straight from the inputs
    // (single-cycle SRAM) or from the request latched when wait states began.
    logic              acc_go;
    logic [ADDR_W-1:0] acc_idx;
    logic [3:0]        acc_wen;
    logic [31:0]       acc_wdata;
    logic              acc_bad;
    logic              mem_we;

    assign in_idx = data_sram_addr[ADDR_W+1:2];

`ifdef DSRAM_ERR_EN
    assign in_bad = |data_sram_addr[31:ADDR_W+2];
`else
    assign in_bad = 1'b0;
`endif

    // Byte offset is EX's job; upper bits alias unless the error check is on.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};

    // Select which request (live or latched) reaches the array this cycle.
    always_comb begin
        acc_go    = 1'b0;
        acc_idx   = in_idx;
        acc_wen   = data_sram_wen;
        acc_wdata = data_sram_wdata;
        acc_bad   = in_bad;
        if (state_q == S_IDLE && data_sram_en && WAIT_CYCLES == 0) begin
            acc_go = 1'b1;
        end else if (state_q == S_WAIT && cnt_q == WC) begin
            acc_go    = 1'b1;
            acc_idx   = idx_q;
            acc_wen   = wen_q;
            acc_wdata = wdata_q;
            acc_bad   = bad_q;
        end
    end

    // A reset in WAIT/DONE must abort a pending write, so rst gates the array.
    assign mem_we = acc_go && !acc_bad && !rst && (acc_wen != 4'b0000);

    // Stall starts combinationally in the accept cycle so EX holds its request.
    assign stallreq = (state_q == S_WAIT) ||
                      (state_q == S_IDLE && data_sram_en && WAIT_CYCLES != 0);

    assign data_sram_rdata = rdata_q;
    assign err             = err_q;

    // Storage array: per-lane write, never cleared by reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && acc_wen[i]) begin
                mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // Access FSM with registered read data and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wen_q   <= 4'b0000;
            wdata_q <= 32'd0;
            bad_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (acc_go) begin
                err_q <= acc_bad;
                if (acc_wen == 4'b0000) begin
                    rdata_q <= acc_bad ? 32'hDEADBEEF : mem[acc_idx];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (data_sram_en && WAIT_CYCLES != 0) begin
                        idx_q   <= in_idx;
                        wen_q   <= data_sram_wen;
                        wdata_q <= data_sram_wdata;
                        bad_q   <= in_bad;
                        cnt_q   <= 4'd1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WC) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    // en here is the same held request being released.
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
